prog_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 22 ++
 rtl/prog_loader_word_assembler.sv | 42 ++++
 rtl/prog_loader.sv | 105 ++++++++++
 tb/tb_prog_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types for the boot-time program loader: FSM states and frame layout constants.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
  localparam int WORD_BYTES = 4;

  // States in which the loader still wants bytes from upstream.
  function automatic logic is_loading(input state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word packer; word and word_done are registered and
// appear the cycle after the 4th byte is taken.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_done
);

  logic [WORD_BYTES-2:0][7:0] lanes;

  // Only the low three lanes are stored; the top byte goes straight into word.
  for (genvar g = 0; g < WORD_BYTES - 1; g++) begin : g_lane
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        lanes[g] <= '0;
      else if (in_valid && byte_idx == 2'(g))
        lanes[g] <= in_byte;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_idx  <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= in_valid && (byte_idx == 2'd3);
      if (in_valid) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3)
          word <= {in_byte, lanes[2], lanes[1], lanes[0]};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a framed, XOR-checked image byte by byte, writes it into
// instruction memory and releases the core only after the checksum matches.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  state_t          state;
  logic [15:0]     count;
  logic [ADDR_W:0] word_cnt;
  logic [7:0]      csum_acc;
  logic [1:0]      byte_idx;
  logic            accept;
  logic            data_take;
  logic [15:0]     hdr_count;
  logic [15:0]     next_cnt;

  // rx_ready is only ever high in loading states, so it alone qualifies a byte.
  assign accept    = rx_valid && rx_ready;
  assign data_take = accept && (state == DATA);
  assign hdr_count = {rx_data, count[7:0]};
  assign next_cnt  = 16'(word_cnt) + 16'd1;

  word_assembler u_asm (
    .clock    (clock),
    .reset    (reset),
    .in_valid (data_take),
    .in_byte  (rx_data),
    .byte_idx (byte_idx),
    .word     (wr_data),
    .word_done(wr_en)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= HDR_LO;
      count     <= '0;
      word_cnt  <= '0;
      csum_acc  <= '0;
      wr_addr   <= '0;
      rx_ready  <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rx_ready <= is_loading(state);
      if (accept) begin
        unique case (state)
          HDR_LO: begin
            count[7:0] <= rx_data;
            state      <= HDR_HI;
          end
          HDR_HI: begin
            count <= hdr_count;
            if (hdr_count > 16'(MAX_WORDS)) begin
              state    <= ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (hdr_count == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            csum_acc <= csum_acc ^ rx_data;
            if (byte_idx == 2'd3) begin
              wr_addr  <= word_cnt[ADDR_W-1:0];
              word_cnt <= word_cnt + 1'b1;
              if (next_cnt == count)
                state <= CSUM;
            end
          end
          CSUM: begin
            rx_ready <= 1'b0;
            if (rx_data == csum_acc) begin
              state     <= RUN;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader plus hand-written timing/reset sequences.
module tb_prog_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];
  int                b2b = 0;
  logic              prev_wr = 1'b0;
  always @(negedge clock) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      if (prev_wr) b2b++;
    end
    prev_wr = wr_en;
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    wq_addr.delete();
    wq_data.delete();
    b2b = 0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Called just after a falling edge; ok reports whether the byte was consumed.
  task automatic send(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 8 && !ok; t++) begin
      ok = rx_ready;
      @(negedge clock);
    end
    rx_valid = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] bytes;   // first byte at MSB
    int           n;
    bit           gappy;
    int           exp_acc;
    int           exp_wr;
    logic [95:0]  exp_data; // first word at MSB
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  function automatic vec_t mk(input string name, input logic [127:0] raw, input int n,
                              input bit gappy, input int acc, input int nw,
                              input logic [95:0] dat, input bit d, input bit e);
    vec_t v;
    v.name = name; v.n = n; v.gappy = gappy; v.exp_acc = acc; v.exp_wr = nw;
    v.bytes = raw << ((16 - n) * 8);
    v.exp_data = (nw == 0) ? '0 : dat << ((3 - nw) * 32);
    v.exp_done = d; v.exp_err = e;
    return v;
  endfunction

  vec_t tbl[7];

  initial begin
    bit ok;
    int acc;
    logic [7:0] b;

    tbl[0] = mk("n2_good", {8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90},
                11, 0, 11, 2, {32'h00000013, 32'h00100093}, 1, 0);
    tbl[1] = mk("n2_badcs", {8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h91},
                11, 0, 11, 2, {32'h00000013, 32'h00100093}, 0, 1);
    tbl[2] = mk("n0_good", {8'h00,8'h00,8'h00,8'h55}, 4, 0, 3, 0, '0, 1, 0);
    tbl[3] = mk("n0_badcs", {8'h00,8'h00,8'h01}, 3, 0, 3, 0, '0, 0, 1);
    tbl[4] = mk("oversize", {8'h01,8'h04,8'h00,8'h00,8'h00}, 5, 0, 2, 0, '0, 0, 1);
    tbl[5] = mk("n1_gaps", {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22}, 7, 1, 7, 1,
                {32'hDEADBEEF}, 1, 0);
    tbl[6] = mk("n3_good", {8'h03,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,
                            8'h09,8'h0A,8'h0B,8'h0C,8'h0C}, 15, 0, 15, 3,
                {32'h04030201, 32'h08070605, 32'h0C0B0A09}, 1, 0);

    // Reset values, held while reset is asserted.
    repeat (2) @(negedge clock);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", 32'(rx_ready), 1);

    foreach (tbl[k]) begin
      do_reset();
      acc = 0;
      for (int i = 0; i < tbl[k].n; i++) begin
        b = tbl[k].bytes[127 - 8*i -: 8];
        send(b, tbl[k].gappy ? ((i % 3 == 1) ? 5 : int'($urandom_range(0, 2))) : 0, ok);
        if (!ok) break;
        acc++;
      end
      repeat (2) @(negedge clock);
      chk({tbl[k].name, "_accepted"}, 32'(acc), 32'(tbl[k].exp_acc));
      chk({tbl[k].name, "_nwrites"}, 32'(wq_addr.size()), 32'(tbl[k].exp_wr));
      for (int w = 0; w < tbl[k].exp_wr && w < wq_addr.size(); w++) begin
        chk({tbl[k].name, "_addr"}, 32'(wq_addr[w]), 32'(w));
        chk({tbl[k].name, "_data"}, wq_data[w], tbl[k].exp_data[95 - 32*w -: 32]);
      end
      chk({tbl[k].name, "_done"}, 32'(done), 32'(tbl[k].exp_done));
      chk({tbl[k].name, "_error"}, 32'(error), 32'(tbl[k].exp_err));
      chk({tbl[k].name, "_cpu_reset"}, 32'(cpu_reset), 32'(!tbl[k].exp_done));
      chk({tbl[k].name, "_rx_ready"}, 32'(rx_ready), 0);
      chk({tbl[k].name, "_b2b"}, 32'(b2b), 0);
    end

    // Exact write-pulse and release timing on a gap-free N=1 image.
    do_reset();
    send(8'h01, 0, ok); send(8'h00, 0, ok);
    send(8'hEF, 0, ok); send(8'hBE, 0, ok); send(8'hAD, 0, ok);
    chk("t_wr_idle", 32'(wr_en), 0);
    send(8'hDE, 0, ok);
    chk("t_wr_pulse", 32'(wr_en), 1);
    chk("t_wr_addr", 32'(wr_addr), 0);
    chk("t_wr_data", wr_data, 32'hDEADBEEF);
    chk("t_pre_done", 32'(done), 0);
    chk("t_pre_cpu_reset", 32'(cpu_reset), 1);
    send(8'h22, 0, ok);
    chk("t_wr_single", 32'(wr_en), 0);
    chk("t_done", 32'(done), 1);
    chk("t_cpu_reset", 32'(cpu_reset), 0);
    chk("t_rx_ready", 32'(rx_ready), 0);
    send(8'h33, 0, ok);
    chk("t_run_ignores", 32'(ok), 0);

    // Header exactly MAX_WORDS is legal.
    do_reset();
    send(8'h00, 0, ok); send(8'h04, 0, ok);
    @(negedge clock);
    chk("max_no_error", 32'(error), 0);
    chk("max_ready", 32'(rx_ready), 1);

    // Reset after 6 of 8 payload bytes, then a fresh N=1 load.
    do_reset();
    send(8'h02, 0, ok); send(8'h00, 0, ok);
    send(8'h13, 0, ok); send(8'h00, 0, ok); send(8'h00, 0, ok); send(8'h00, 0, ok);
    send(8'h93, 0, ok); send(8'h00, 0, ok);
    chk("mid_first_write", 32'(wq_addr.size()), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_rx_ready", 32'(rx_ready), 0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 1);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    do_reset();
    send(8'h01, 0, ok); send(8'h00, 0, ok);
    send(8'hEF, 0, ok); send(8'hBE, 0, ok); send(8'hAD, 0, ok); send(8'hDE, 0, ok);
    send(8'h22, 0, ok);
    chk("mid_nwrites", 32'(wq_addr.size()), 1);
    if (wq_addr.size() > 0) begin
      chk("mid_addr", 32'(wq_addr[0]), 0);
      chk("mid_data", wq_data[0], 32'hDEADBEEF);
    end
    chk("mid_done", 32'(done), 1);
    chk("mid_error", 32'(error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
